// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared encodings for the iterative RV32M multiply/divide unit:
//   FUNCT3 opcodes, FSM state type and iteration count.
package mul_div_unit_pkg;

   // RV32M FUNCT3 encodings
   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   // One result bit per cycle over a 32-bit operand
   localparam int         MDU_ITER      = 32;
   localparam logic [4:0] MDU_LAST_ITER = 5'(MDU_ITER - 1);

   typedef enum logic [1:0] {
      MDU_STATE_IDLE = 2'd0,
      MDU_STATE_RUN  = 2'd1,
      MDU_STATE_DONE = 2'd2
   } mdu_state_t;

   // FUNCT3[2] separates the divide family from the multiply family
   function automatic logic mdu_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative RV32M multiply/divide unit. Multiply is radix-2 shift-add,
//   divide is restoring; both run 32 iterations over a shared 64-bit
//   accumulator, 32-bit operand register and 5-bit counter. Operands are
//   converted to magnitudes on accept and the sign is fixed up on the edge
//   that enters DONE. Divide-by-zero and signed overflow finish in one cycle.
//
// Ports
//   CLK     in   system clock, rising edge
//   RST     in   synchronous active-high reset
//   START   in   request; honoured in IDLE or DONE only
//   FUNCT3  in   [2:0] RV32M operation
//   A       in   [31:0] rs1 (multiplicand / dividend)
//   B       in   [31:0] rs2 (multiplier / divisor)
//   BUSY    out  high while iterating
//   DONE    out  one-cycle pulse, RESULT valid
//   RESULT  out  [31:0] result, held until the next completed operation
module mul_div_unit
   import mul_div_unit_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] RESULT
);

   mdu_state_t  state_reg, state_next;
   logic [4:0]  cnt_reg;
   logic [63:0] acc_reg;
   logic [31:0] op_reg;
   logic [2:0]  funct3_reg;
   logic        neg_reg;
   logic [31:0] result_reg;

   // ---------------- accept-time decode ----------------
   logic        accept;
   logic        a_signed, b_signed;
   logic [31:0] a_mag, b_mag;
   logic        neg_next;
   logic        div_zero, div_ovf, special;
   logic [31:0] special_result;

   assign accept = START && (state_reg != MDU_STATE_RUN);

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      neg_next = 1'b0;
      case (FUNCT3)
         MDU_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; neg_next = A[31] ^ B[31]; end
         MDU_MULHSU: begin a_signed = 1'b1;                  neg_next = A[31];         end
         MDU_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; neg_next = A[31] ^ B[31]; end
         MDU_REM:    begin a_signed = 1'b1; b_signed = 1'b1; neg_next = A[31];         end
         default:    ;
      endcase
   end

   assign a_mag = (a_signed && A[31]) ? (32'd0 - A) : A;
   assign b_mag = (b_signed && B[31]) ? (32'd0 - B) : B;

   assign div_zero = mdu_is_div(FUNCT3) && (B == 32'd0);
   assign div_ovf  = ((FUNCT3 == MDU_DIV) || (FUNCT3 == MDU_REM)) &&
                     (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
   assign special  = div_zero || div_ovf;

   // FUNCT3[1] picks remainder over quotient within the divide family
   always_comb begin
      special_result = 32'd0;
      if (div_zero)
         special_result = FUNCT3[1] ? A : 32'hFFFF_FFFF;
      else if (div_ovf)
         special_result = FUNCT3[1] ? 32'd0 : 32'h8000_0000;
   end

   // ---------------- one iteration ----------------
   // Multiply: acc = {partial product high, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   logic [32:0] div_trial;
   logic [63:0] div_step;
   logic [63:0] acc_step;

   assign mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? op_reg : 32'd0)};
   assign mul_step  = {mul_sum, acc_reg[31:1]};
   assign div_trial = acc_reg[63:31] - {1'b0, op_reg};
   assign div_step  = div_trial[32] ? {acc_reg[62:0], 1'b0}
                                    : {div_trial[31:0], acc_reg[30:0], 1'b1};
   assign acc_step  = mdu_is_div(funct3_reg) ? div_step : mul_step;

   // ---------------- sign fix-up on the final iteration ----------------
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;
   logic [31:0] final_result;

   assign prod_fix = neg_reg ? (64'd0 - acc_step) : acc_step;
   assign quot_fix = neg_reg ? (32'd0 - acc_step[31:0]) : acc_step[31:0];
   assign rem_fix  = neg_reg ? (32'd0 - acc_step[63:32]) : acc_step[63:32];

   always_comb begin
      final_result = prod_fix[63:32];
      case (funct3_reg)
         MDU_MUL:           final_result = prod_fix[31:0];
         MDU_DIV, MDU_DIVU: final_result = quot_fix;
         MDU_REM, MDU_REMU: final_result = rem_fix;
         default:           final_result = prod_fix[63:32];
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge CLK) begin
      if (RST)
         state_reg <= MDU_STATE_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         MDU_STATE_IDLE: begin
            if (START)
               state_next = special ? MDU_STATE_DONE : MDU_STATE_RUN;
         end
         MDU_STATE_RUN: begin
            if (cnt_reg == MDU_LAST_ITER)
               state_next = MDU_STATE_DONE;
         end
         MDU_STATE_DONE: begin
            if (START)
               state_next = special ? MDU_STATE_DONE : MDU_STATE_RUN;
            else
               state_next = MDU_STATE_IDLE;
         end
         default: state_next = MDU_STATE_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_reg    <= 5'd0;
         acc_reg    <= 64'd0;
         op_reg     <= 32'd0;
         funct3_reg <= 3'd0;
         neg_reg    <= 1'b0;
         result_reg <= 32'd0;
      end else if (accept) begin
         cnt_reg    <= 5'd0;
         funct3_reg <= FUNCT3;
         neg_reg    <= neg_next;
         // Divide iterates the dividend through the low half; multiply
         // iterates the multiplier.
         op_reg     <= mdu_is_div(FUNCT3) ? b_mag : a_mag;
         acc_reg    <= {32'd0, (mdu_is_div(FUNCT3) ? a_mag : b_mag)};
         if (special)
            result_reg <= special_result;
      end else if (state_reg == MDU_STATE_RUN) begin
         acc_reg <= acc_step;
         cnt_reg <= 5'(cnt_reg + 5'd1);
         if (cnt_reg == MDU_LAST_ITER)
            result_reg <= final_result;
      end
   end

   assign BUSY   = (state_reg == MDU_STATE_RUN);
   assign DONE   = (state_reg == MDU_STATE_DONE);
   assign RESULT = result_reg;

endmodule
